// File: rtl/serial_word_rx_if.sv
// serial_word_rx_if: ready/valid word output bundle of the serial receiver.
interface serial_word_rx_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/serial_word_rx.sv
// serial_word_rx: idle-low serial word receiver with a one-entry ready/valid buffer.
// Optional even-parity bit: define SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int WORD_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  serial_word_rx_if.master rx,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);
  // The IDLE detection edge is bit-cycle 0, so START sees bit-cycle N at cyc_r == N-1.
  localparam logic [7:0] CYC_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] CYC_MID  = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0] BIT_LAST = 5'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_WORD_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t            state_r, state_nx;
  logic [7:0]        cyc_r, cyc_nx;
  logic [4:0]        bit_r, bit_nx;
  logic [WORD_W-1:0] shift_r, shift_nx;
  logic              data_smp_s, stop_smp_s, word_ok_s, word_bad_s;

`ifdef SERIAL_WORD_RX_PARITY_EN
  logic par_r, par_smp_s;

  function automatic logic even_par(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`endif

  // State and bit/cycle counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cyc_r   <= 8'd0;
      bit_r   <= 5'd0;
    end else begin
      state_r <= state_nx;
      cyc_r   <= cyc_nx;
      bit_r   <= bit_nx;
    end
  end

  // Next-state, counter and sample-strobe logic
  always_comb begin
    state_nx   = state_r;
    cyc_nx     = cyc_r;
    bit_nx     = bit_r;
    data_smp_s = 1'b0;
    stop_smp_s = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
    par_smp_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        cyc_nx = 8'd0;
        bit_nx = 5'd0;
        if (din) state_nx = START;
        else     state_nx = IDLE;
      end
      START: begin
        if (cyc_r == CYC_MID) begin
          cyc_nx = 8'd0;
          if (din) state_nx = DATA;
          else     state_nx = IDLE;
        end else begin
          cyc_nx = cyc_r + 8'd1;
        end
      end
      DATA: begin
        if (cyc_r == CYC_LAST) begin
          data_smp_s = 1'b1;
          cyc_nx     = 8'd0;
          if (bit_r == BIT_LAST) begin
            bit_nx = 5'd0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_nx = bit_r + 5'd1;
          end
        end else begin
          cyc_nx = cyc_r + 8'd1;
        end
      end
`ifdef SERIAL_WORD_RX_PARITY_EN
      PARITY: begin
        if (cyc_r == CYC_LAST) begin
          par_smp_s = 1'b1;
          cyc_nx    = 8'd0;
          state_nx  = STOP;
        end else begin
          cyc_nx = cyc_r + 8'd1;
        end
      end
`endif
      STOP: begin
        if (cyc_r == CYC_LAST) begin
          stop_smp_s = 1'b1;
          cyc_nx     = 8'd0;
          state_nx   = IDLE;
        end else begin
          cyc_nx = cyc_r + 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cyc_nx   = 8'd0;
        bit_nx   = 5'd0;
      end
    endcase

    shift_nx = shift_r;
    if (data_smp_s) begin
      for (int i = 0; i < WORD_W - 1; i++) shift_nx[i] = shift_r[i+1];
      shift_nx[WORD_W-1] = din;
    end else begin
      shift_nx = shift_r;
    end
  end

  // Data shift register, LSB received first
  always_ff @(posedge clk) begin
    if (rst) shift_r <= {WORD_W{1'b0}};
    else     shift_r <= shift_nx;
  end

`ifdef SERIAL_WORD_RX_PARITY_EN
  // Captured parity bit
  always_ff @(posedge clk) begin
    if (rst)            par_r <= 1'b0;
    else if (par_smp_s) par_r <= din;
    else                par_r <= par_r;
  end

  assign word_ok_s = stop_smp_s && !din && (even_par(shift_r) == par_r);
`else
  assign word_ok_s = stop_smp_s && !din;
`endif
  assign word_bad_s = stop_smp_s && !word_ok_s;
  assign busy       = (state_r != IDLE);

  // Output buffer, handshake and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rx.dout       <= {WORD_W{1'b0}};
      rx.dout_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= word_bad_s;
      overrun   <= 1'b0;
      if (word_ok_s) begin
        if (!rx.dout_valid || rx.dout_ready) begin
          rx.dout       <= shift_r;
          rx.dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx.dout_valid && rx.dout_ready) begin
        rx.dout_valid <= 1'b0;
      end else begin
        rx.dout_valid <= rx.dout_valid;
      end
    end
  end
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: per-cycle stimulus tables built from the frame format, checked
// against a word-level model of the output buffer, flags and busy.
module tb_serial_word_rx;
  localparam int CPB  = 4;
  localparam int W    = 8;
  localparam int HALF = CPB / 2;
`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic clk = 1'b0;
  logic rst, din, busy, frame_err, overrun;
  int   total = 0;
  int   bad   = 0;

  serial_word_rx_if #(.WORD_W(W)) rx_bus ();

  serial_word_rx #(.CLKS_PER_BIT(CPB), .WORD_W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .rx(rx_bus),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Per-cycle tables: inputs at edge k, expected busy after edge k, event at edge k
  bit             q_din[$], q_rst[$], q_rdy[$], q_busy[$];
  int             q_ev[$];
  logic [W-1:0]   q_word[$];
  int             rdy_mode = 0;

  logic         m_valid, m_fe, m_ov, m_busy;
  logic [W-1:0] m_dout;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic push(input bit d, input bit r, input bit b);
    q_din.push_back(d);
    q_rst.push_back(r);
    q_busy.push_back(b);
    q_ev.push_back(0);
    q_word.push_back({W{1'b0}});
    if (rdy_mode == 0)      q_rdy.push_back(1'b1);
    else if (rdy_mode == 1) q_rdy.push_back(1'b0);
    else                    q_rdy.push_back($urandom_range(0, 3) != 0);
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b0);
  endtask

  // Frame: start=1, data LSB first, [even parity], stop=0; stop sampled mid-bit
  task automatic add_frame(input logic [W-1:0] w, input bit stop_bad, input bit par_bad);
    int s      = q_din.size();
    int stop_k = s + (NB - 1) * CPB + HALF;
    bit bits[$];
    bits.push_back(1'b1);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef SERIAL_WORD_RX_PARITY_EN
    bits.push_back((^w) ^ par_bad);
`endif
    bits.push_back(stop_bad);
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < CPB; c++) begin
        int k = s + b * CPB + c;
        bit v = bits[b];
        if (b == NB - 1 && c > HALF) v = 1'b0;
        push(v, 1'b0, (k < stop_k));
      end
`ifdef SERIAL_WORD_RX_PARITY_EN
    q_ev[stop_k] = (stop_bad || par_bad) ? 2 : 1;
`else
    q_ev[stop_k] = stop_bad ? 2 : 1;
`endif
    q_word[stop_k] = w;
  endtask

  // Short high glitch: START re-checks din at bit-cycle HALF and drops back to IDLE
  task automatic add_pulse(input int len);
    for (int i = 0; i < HALF; i++) push(i < len, 1'b0, 1'b1);
    add_gap(2);
  endtask

  // Start bit plus four data bits of 0xFF, then reset
  task automatic add_abort();
    for (int i = 0; i < 5 * CPB; i++) push(1'b1, 1'b0, 1'b1);
    add_reset(1);
  endtask

  initial begin
    rdy_mode = 0;
    add_reset(3);
    add_gap(2);
    add_frame(8'hA5, 1'b0, 1'b0);
    add_gap(3);
    add_pulse(1);
    add_frame(8'h3C, 1'b1, 1'b0);
    add_gap(2);
    rdy_mode = 1;
    add_frame(8'h11, 1'b0, 1'b0);
    add_frame(8'h22, 1'b0, 1'b0);
    add_gap(2);
    rdy_mode = 0;
    add_gap(3);
    add_abort();
    add_gap(2);
    add_frame(8'h5A, 1'b0, 1'b0);
    add_gap(2);
`ifdef SERIAL_WORD_RX_PARITY_EN
    add_frame(8'h07, 1'b0, 1'b1);
    add_frame(8'h07, 1'b0, 1'b0);
    add_gap(2);
`endif
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int r = $urandom_range(0, 9);
      if (r == 0)      add_pulse($urandom_range(1, HALF));
      else if (r == 1) add_frame(W'($urandom), 1'b1, 1'b0);
`ifdef SERIAL_WORD_RX_PARITY_EN
      else if (r == 2) add_frame(W'($urandom), 1'b0, 1'b1);
`endif
      else if (r == 3) add_reset(1);
      else             add_frame(W'($urandom), 1'b0, 1'b0);
      add_gap($urandom_range(0, 2));
    end
    rdy_mode = 0;
    add_gap(4);

    for (int k = 0; k < q_din.size(); k++) begin
      din                 = q_din[k];
      rst                 = q_rst[k];
      rx_bus.dout_ready   = q_rdy[k];
      @(posedge clk);
      if (q_rst[k]) begin
        m_valid = 1'b0; m_dout = {W{1'b0}}; m_fe = 1'b0; m_ov = 1'b0;
      end else begin
        m_fe = (q_ev[k] == 2);
        m_ov = 1'b0;
        if (q_ev[k] == 1) begin
          if (!m_valid || q_rdy[k]) begin
            m_dout  = q_word[k];
            m_valid = 1'b1;
          end else begin
            m_ov = 1'b1;
          end
        end else if (m_valid && q_rdy[k]) begin
          m_valid = 1'b0;
        end
      end
      m_busy = q_busy[k];
      @(negedge clk);
      check_val("dout_valid", 32'(rx_bus.dout_valid), 32'(m_valid));
      check_val("dout", 32'(rx_bus.dout), 32'(m_dout));
      check_val("frame_err", 32'(frame_err), 32'(m_fe));
      check_val("overrun", 32'(overrun), 32'(m_ov));
      check_val("busy", 32'(busy), 32'(m_busy));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clk cycles per serial bit; legal range 2..255.
REQ-002 Parameter WORD_W, default 8: data bits per frame; legal range 1..16.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 din  input  1  serial line, idle-low, driven by the dff serial stage; synchronous to clk.
REQ-006 dout  output  WORD_W  received word, LSB = first data bit.
REQ-007 dout_valid  output  1  dout holds an unconsumed word.
REQ-008 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-009 busy  output  1  frame in progress (state != IDLE).
REQ-010 frame_err  output  1  one-cycle pulse: bad stop (or parity) bit.
REQ-011 overrun  output  1  one-cycle pulse: good word dropped, buffer full.

Function
REQ-012 Frame format: start bit = 1, WORD_W data bits LSB first, [parity bit], stop bit = 0.
REQ-013 FSM states: IDLE, START, DATA, PARITY (macro only), STOP; the FSM SHALL hold no other states.
REQ-014 IDLE: din==1 -> START, bit counter cleared, cycle counter cleared.
REQ-015 START: at cycle CLKS_PER_BIT/2 (integer), din==1 -> DATA with counter cleared; din==0 -> IDLE (false start, no flags).
REQ-016 DATA: sample din every CLKS_PER_BIT cycles into shift register; after WORD_W samples -> PARITY or STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; din==0 with parity good -> word complete; otherwise frame_err pulse, word discarded; both -> IDLE.
REQ-018 Word complete, !dout_valid or dout_ready same cycle: dout and dout_valid=1 load next cycle (latency 1 after stop sample).
REQ-019 Word complete, dout_valid && !dout_ready: new word dropped, dout unchanged, overrun pulses 1 cycle.
REQ-020 dout_valid && dout_ready with no completion: dout_valid clears next cycle; dout holds last value.
REQ-021 dout SHALL stay stable while dout_valid && !dout_ready.
REQ-022 Return to IDLE occurs the cycle after the stop sample; back-to-back frames are accepted without gap.
REQ-023 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-024 rst high at posedge: state=IDLE, counters=0, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
REQ-025 Reset mid-frame SHALL abort the frame; the partial word is discarded, no flag pulses.
REQ-026 rst overrides all other inputs, including dout_ready and din.

Configuration
REQ-027 Macro SERIAL_WORD_RX_PARITY_EN defined: PARITY state present; one even-parity bit follows data; mismatch -> frame_err at STOP, word discarded.
REQ-028 Macro undefined: no PARITY state, no parity bit; frame is start + WORD_W data + stop.

Verification
REQ-029 Defaults, no parity, dout_ready=1: send 0xA5 frame -> dout=8'hA5, dout_valid 1 cycle, no flags.
REQ-030 din pulses high 1 cycle in IDLE (< CLKS_PER_BIT/2) -> returns IDLE, dout_valid stays 0, no flags.
REQ-031 Send 0x3C with stop bit = 1 -> frame_err one pulse, dout_valid stays 0.
REQ-032 dout_ready=0, send 0x11 then 0x22 -> dout=8'h11 held, overrun pulse at second completion; dout_ready=1 -> consumes 0x11.
REQ-033 rst asserted after 4th data bit of 0xFF, then send 0x5A -> only 8'h5A delivered.
REQ-034 SERIAL_WORD_RX_PARITY_EN, send 0x07 with parity 0 -> frame_err; with parity 1 -> dout=8'h07.
